subword_mem_ctrl: RTL and testbench

Sequential memory-side controller that executes byte, halfword and word loads and stores against a word-only, synchronous-read data memory. Sub-word stores are performed as read-modify-write: read the containing word, merge the new lane(s), write the word back. Sub-word loads are extracted and sign-extended. It sits between the datapath's load/store request and the data memory, and it replaces combinational lane merging with a handshaked multi-cycle sequence.

---
 rtl/subword_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_subword_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subword_mem_ctrl.sv
// subword_mem_ctrl: byte/halfword/word load-store sequencer over a word-only, synchronous-read RAM.
// Define SUBWORD_ALIGN_CHECK_EN to reject misaligned halfword/word requests with resp_err.
module subword_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [5:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       resp_data_reg;
  logic              err_reg;

  logic req_legal, req_misaligned, req_reject, op_is_load;

  assign req_legal = (req_op == OP_LW) || (req_op == OP_LH) || (req_op == OP_LB) ||
                     (req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB);

`ifdef SUBWORD_ALIGN_CHECK_EN
  assign req_misaligned = (((req_op == OP_LH) || (req_op == OP_SH)) && req_addr[0]) ||
                          (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_reject = !req_legal || req_misaligned;
  assign op_is_load = (op_reg == OP_LW) || (op_reg == OP_LH) || (op_reg == OP_LB);

  // Store merge: each byte lane either keeps the read word or takes the new store data.
  logic [31:0] sb_word, sh_word, wr_word;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign sb_word[8*gi +: 8] = (addr_reg[1:0] == 2'(gi)) ? wdata_reg[7:0]
                                                            : rdata_reg[8*gi +: 8];
      assign sh_word[8*gi +: 8] = (addr_reg[1] == 1'(gi / 2)) ? wdata_reg[8*(gi % 2) +: 8]
                                                              : rdata_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    case (op_reg)
      OP_SB:   wr_word = sb_word;
      OP_SH:   wr_word = sh_word;
      default: wr_word = wdata_reg;
    endcase
  end

  // Load extraction works on the RAM output directly so the result is ready when RESP starts.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;
  assign ld_byte = mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
  assign ld_half = mem_rdata[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (op_reg)
      OP_LB:   ld_word = {{24{ld_byte[7]}}, ld_byte};
      OP_LH:   ld_word = {{16{ld_half[15]}}, ld_half};
      default: ld_word = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if (req_reject)          state_next = S_RESP;
          else if (req_op == OP_SW) state_next = S_WR;
          else                     state_next = S_RD;
        end
      end
      S_RD:    state_next = S_WAIT;
      S_WAIT:  state_next = op_is_load ? S_RESP : S_WR;
      S_WR:    state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      resp_data_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            op_reg        <= req_op;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            err_reg       <= req_reject;
            resp_data_reg <= '0;
          end
        end
        S_WAIT: begin
          rdata_reg <= mem_rdata;
          if (op_is_load) resp_data_reg <= ld_word;
        end
        S_WR:    resp_data_reg <= wr_word;
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_reg == S_IDLE);
  assign mem_rd_en  = (state_reg == S_RD);
  assign mem_wr_en  = (state_reg == S_WR);
  assign mem_addr   = {addr_reg[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = (state_reg == S_WR) ? wr_word : 32'h0;
  assign resp_valid = (state_reg == S_RESP);
  assign resp_err   = (state_reg == S_RESP) && err_reg;
  assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Randomized bench for subword_mem_ctrl: a small synchronous RAM plus a behavioural model of
// lane extraction/merging, strobe timing and response latency.
module tb_subword_mem_ctrl;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  subword_mem_ctrl #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err)
  );

  int checks = 0;
  int errors = 0;

  // Word-only synchronous RAM; pre_* is a side port used to load known contents.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_word;

  always @(posedge clk) begin
    if (pre_we)    mem[pre_idx] <= pre_word;
    if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr[5:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: expected timing (cycles after accept edge), result and memory word.
  function automatic void model(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] old,
                                output int lat, output int rd_cyc, output int wr_cyc,
                                output logic [31:0] data, output logic err,
                                output logic [31:0] new_word);
    int n, h;
    logic legal, mis;
    logic [7:0]  b;
    logic [15:0] hw;
    n = int'(addr[1:0]);
    h = int'(addr[1]);
    new_word = old; rd_cyc = 0; wr_cyc = 0; data = 32'h0; err = 1'b0; lat = 1;
    legal = (op == OP_LW) || (op == OP_LH) || (op == OP_LB) ||
            (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    mis = 1'b0;
`ifdef SUBWORD_ALIGN_CHECK_EN
    mis = (((op == OP_LH) || (op == OP_SH)) && addr[0]) ||
          (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00));
`endif
    if (!legal || mis) begin
      err = 1'b1;
      return;
    end
    case (op)
      OP_LW: begin lat = 3; rd_cyc = 1; data = old; end
      OP_LH: begin
        lat = 3; rd_cyc = 1;
        hw = 16'((old >> (16 * h)) & 32'hFFFF);
        data = {{16{hw[15]}}, hw};
      end
      OP_LB: begin
        lat = 3; rd_cyc = 1;
        b = 8'((old >> (8 * n)) & 32'hFF);
        data = {{24{b[7]}}, b};
      end
      OP_SW: begin lat = 2; wr_cyc = 1; new_word = wd; data = wd; end
      OP_SH: begin
        lat = 4; rd_cyc = 1; wr_cyc = 3;
        new_word = (old & ~(32'hFFFF << (16 * h))) | ((wd & 32'hFFFF) << (16 * h));
        data = new_word;
      end
      default: begin
        lat = 4; rd_cyc = 1; wr_cyc = 3;
        new_word = (old & ~(32'hFF << (8 * n))) | ((wd & 32'hFF) << (8 * n));
        data = new_word;
      end
    endcase
  endfunction

  task automatic preload(input logic [3:0] idx, input logic [31:0] word);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_word = word;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = word;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_idle", 32'(req_ready), 32'h1);
  endtask

  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic pre_ready, input int hold,
                         input logic lit_en, input logic [31:0] lit);
    int lat, rd_cyc, wr_cyc, k;
    logic [31:0] data, new_word, old;
    logic err, seen;
    old = ref_mem[addr[5:2]];
    model(op, addr, wd, old, lat, rd_cyc, wr_cyc, data, err, new_word);
    wait_ready();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; resp_ready = pre_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
    k = 0; seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      k++;
      check("rd_en", 32'(mem_rd_en), 32'(k == rd_cyc));
      check("wr_en", 32'(mem_wr_en), 32'(k == wr_cyc));
      if (mem_rd_en || mem_wr_en) check("mem_addr", mem_addr, {addr[31:2], 2'b00});
      if (mem_wr_en) check("mem_wdata", mem_wdata, new_word);
      check("req_ready_busy", 32'(req_ready), 32'h0);
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout: resp_valid not seen, got none expected at cycle %0d", lat);
      pulse_reset();
      return;
    end
    check("latency", 32'(k), 32'(lat));
    check("resp_data", resp_data, data);
    check("resp_err", 32'(resp_err), 32'(err));
    if (lit_en) check("literal", resp_data, lit);
    if (!pre_ready) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", 32'(resp_valid), 32'h1);
        check("hold_data", resp_data, data);
        check("hold_ready", 32'(req_ready), 32'h0);
        check("hold_strobes", 32'(mem_rd_en | mem_wr_en), 32'h0);
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    check("resp_done", 32'(resp_valid), 32'h0);
    check("req_ready_back", 32'(req_ready), 32'h1);
    resp_ready = 1'b0;
    ref_mem[addr[5:2]] = new_word;
    $display("txn op=%b addr=%h wdata=%h -> data=%h err=%b lat=%0d", op, addr, wd, resp_data,
             err, k);
  endtask

  // SB abandoned by reset while waiting on the read: no write, controller idle next cycle.
  task automatic reset_mid_sb(input logic [31:0] addr, input logic [31:0] wd);
    wait_ready();
    req_valid = 1'b1; req_op = OP_SB; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_rd_en", 32'(mem_rd_en), 32'h1);
    @(negedge clk);
    check("rst_wait_wr", 32'(mem_wr_en), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_no_wr", 32'(mem_wr_en), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_no_resp", 32'(resp_valid), 32'h0);
    reset = 1'b0;
    $display("txn op=%b addr=%h wdata=%h -> abandoned by reset", OP_SB, addr, wd);
  endtask

  initial begin
    logic [5:0] op;
    logic [31:0] lit_lh1;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_word = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rd", 32'(mem_rd_en), 32'h0);
    check("rst_wr", 32'(mem_wr_en), 32'h0);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

    preload(4'd1, 32'h1122_3344);
    run_txn(OP_SB, 32'h0000_0006, 32'h0000_00AB, 1'b0, 1, 1'b1, 32'h11AB_3344);
    preload(4'd0, 32'h1122_3344);
    run_txn(OP_SH, 32'h0000_0002, 32'h0000_BEEF, 1'b0, 0, 1'b1, 32'hBEEF_3344);
    preload(4'd0, 32'h8012_3456);
    run_txn(OP_LB, 32'h0000_0003, $urandom, 1'b1, 0, 1'b1, 32'hFFFF_FF80);
    preload(4'd0, 32'h8012_7456);
    run_txn(OP_LH, 32'h0000_0000, $urandom, 1'b0, 2, 1'b1, 32'h0000_7456);
    run_txn(OP_SW, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 3, 1'b1, 32'hDEAD_BEEF);
    preload(4'd2, 32'h1122_3344);
    reset_mid_sb(32'h0000_0009, 32'h0000_00CC);
    run_txn(OP_LW, 32'h0000_0008, $urandom, 1'b0, 0, 1'b1, 32'h1122_3344);
`ifdef SUBWORD_ALIGN_CHECK_EN
    lit_lh1 = 32'h0000_0000;
`else
    lit_lh1 = 32'h0000_7456;
`endif
    run_txn(OP_LH, 32'h0000_0001, $urandom, 1'b0, 0, 1'b1, lit_lh1);
    run_txn(6'b000000, 32'h0000_0020, $urandom, 1'b0, 1, 1'b1, 32'h0000_0000);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 6))
        0: op = OP_LW;
        1: op = OP_LH;
        2: op = OP_LB;
        3: op = OP_SW;
        4: op = OP_SH;
        5: op = OP_SB;
        default: begin
          op = 6'($urandom);
          while ((op == OP_LW) || (op == OP_LH) || (op == OP_LB) ||
                 (op == OP_SW) || (op == OP_SH) || (op == OP_SB))
            op = 6'($urandom);
        end
      endcase
      run_txn(op, 32'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'b0, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
